// File: rtl/sprite_pkg.sv
// Shared constants and slot state encoding for the sprite row renderer.
package sprite_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ROW,
    S_ACTIVE,
    S_DONE
  } slot_state_t;
endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: frame shadows, vertical row FSM, horizontal run counters,
// bitmap index register (stage1) and combinational bitmap lookup.
module sprite_slot
  import sprite_pkg::*;
#(
  parameter int SPR_W = 11,
  parameter int SPR_H = 8,
  parameter int CW    = 10
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_pix_en,
  input  logic                   i_frame_start,
  input  logic [CW-1:0]          i_x,
  input  logic [CW-1:0]          i_y,
  input  logic [CW-1:0]          i_x_obj,
  input  logic [CW-1:0]          i_y_obj,
  input  logic                   i_alive,
  input  logic [3:0]             i_mult,
  input  logic [SPR_W*SPR_H-1:0] i_bmp_r,
  input  logic [SPR_W*SPR_H-1:0] i_bmp_g,
  input  logic [SPR_W*SPR_H-1:0] i_bmp_b,
  output logic                   o_r,
  output logic                   o_g,
  output logic                   o_b,
  output logic                   o_opaque
);
  localparam int NPIX  = SPR_W * SPR_H;
  localparam int IDX_W = $clog2(NPIX);
  localparam int COL_W = $clog2(SPR_W);
  localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(NPIX - 1);
  localparam logic [IDX_W-1:0] ROW_STEP  = IDX_W'(SPR_W);
  localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(SPR_W * (SPR_H - 1));
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SPR_W - 1);
  localparam logic [CW-1:0]    X_LAST    = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]    X_LIM     = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    Y_LIM     = CW'(V_ACTIVE);

  logic [CW-1:0]    r_x_lat, r_y_lat;
  logic             r_alive;
  logic [3:0]       r_mult;
  slot_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_base, w_base, w_base_nxt;   // row * SPR_W, kept additively
  logic [3:0]       r_sub_y, w_sub_y, w_sub_y_nxt;
  logic             r_run, w_run_nxt;
  logic [COL_W-1:0] r_col, w_col, w_col_nxt;
  logic [3:0]       r_sub_x, w_sub_x, w_sub_x_nxt;
  logic             w_line_end, w_start_v, w_vact, w_run_start, w_in_run;
  logic [3:0]       w_mult_last;
  logic             r_on;
  logic [IDX_W-1:0] r_idx;

  // Frame shadows: game logic may change inputs at any time, only these are used
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x_lat <= '0;
      r_y_lat <= '0;
      r_alive <= 1'b0;
      r_mult  <= '0;
    end else if (i_frame_start) begin
      r_x_lat <= i_x_obj;
      r_y_lat <= i_y_obj;
      r_alive <= i_alive;
      r_mult  <= (i_mult == 4'd0) ? 4'd1 : i_mult;
    end
  end

  // Next state for the vertical FSM and the run counters. A row that starts on
  // this very pixel (x==0) is treated as already active so X_lat==0 still draws.
  always_comb begin
    w_mult_last = r_mult - 4'd1;
    w_line_end  = i_pix_en && (i_x == X_LAST);
    w_start_v   = i_pix_en && (r_state == S_WAIT_ROW) && (i_x == '0) &&
                  (i_y == r_y_lat) && (r_y_lat < Y_LIM);
    w_vact      = (r_state == S_ACTIVE) || w_start_v;
    w_base      = w_start_v ? '0 : r_base;
    w_sub_y     = w_start_v ? '0 : r_sub_y;
    w_run_start = i_pix_en && w_vact && (i_x == r_x_lat) && (r_x_lat < X_LIM);
    w_in_run    = w_run_start || r_run;
    w_col       = w_run_start ? '0 : r_col;
    w_sub_x     = w_run_start ? '0 : r_sub_x;

    w_state_nxt = r_state;
    w_base_nxt  = w_base;
    w_sub_y_nxt = w_sub_y;
    w_run_nxt   = w_in_run;
    w_col_nxt   = w_col;
    w_sub_x_nxt = w_sub_x;

    if (w_start_v) w_state_nxt = S_ACTIVE;

    if (i_pix_en && w_in_run) begin
      if (w_sub_x == w_mult_last) begin
        w_sub_x_nxt = '0;
        if (w_col == COL_LAST) w_run_nxt = 1'b0;
        else                   w_col_nxt = w_col + COL_W'(1);
      end else begin
        w_sub_x_nxt = w_sub_x + 4'd1;
      end
    end

    // Line end clips the run and steps the vertical scaler
    if (w_line_end) begin
      w_run_nxt = 1'b0;
      if (w_vact) begin
        if (w_sub_y == w_mult_last) begin
          w_sub_y_nxt = '0;
          if (w_base == LAST_BASE) w_state_nxt = S_DONE;
          else                     w_base_nxt  = w_base + ROW_STEP;
        end else begin
          w_sub_y_nxt = w_sub_y + 4'd1;
        end
      end
    end

    if (i_frame_start) begin
      w_state_nxt = S_WAIT_ROW;
      w_run_nxt   = 1'b0;
    end
  end

  // Vertical FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Row/column counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_base  <= '0;
      r_sub_y <= '0;
      r_run   <= 1'b0;
      r_col   <= '0;
      r_sub_x <= '0;
    end else begin
      r_base  <= w_base_nxt;
      r_sub_y <= w_sub_y_nxt;
      r_run   <= w_run_nxt;
      r_col   <= w_col_nxt;
      r_sub_x <= w_sub_x_nxt;
    end
  end

  // Stage1: capture coverage and bitmap index of the presented pixel
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_on  <= 1'b0;
      r_idx <= '0;
    end else if (i_pix_en) begin
      r_on  <= w_in_run && r_alive;
      r_idx <= TOP_IDX - (w_base + IDX_W'(w_col));
    end
  end

  assign o_r      = r_on & i_bmp_r[r_idx];
  assign o_g      = r_on & i_bmp_g[r_idx];
  assign o_b      = r_on & i_bmp_b[r_idx];
  assign o_opaque = o_r | o_g | o_b;
endmodule

// File: rtl/sprite_row_renderer.sv
// Row of NUM_SLOTS scaled sprites: per-slot renderers, OR-merged colour
// (stage2) and sticky shot-hit flags.
module sprite_row_renderer #(
  parameter int NUM_SLOTS = 5,
  parameter int SPR_W     = 11,
  parameter int SPR_H     = 8,
  parameter int COORD_W   = 10
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         PIX_EN,
  input  logic                         FRAME_START,
  input  logic [COORD_W-1:0]           X_VGA,
  input  logic [COORD_W-1:0]           Y_VGA,
  input  logic [NUM_SLOTS*COORD_W-1:0] X_OBJETO,
  input  logic [NUM_SLOTS*COORD_W-1:0] Y_OBJETO,
  input  logic [NUM_SLOTS-1:0]         ALIVE,
  input  logic [3:0]                   MULTIPLICADOR,
  input  logic [SPR_W*SPR_H-1:0]       BITMAP_R,
  input  logic [SPR_W*SPR_H-1:0]       BITMAP_G,
  input  logic [SPR_W*SPR_H-1:0]       BITMAP_B,
  input  logic                         SHOT_PIXEL,
  input  logic [NUM_SLOTS-1:0]         HIT_ACK,
  output logic                         R_VGA,
  output logic                         G_VGA,
  output logic                         B_VGA,
  output logic [NUM_SLOTS-1:0]         HIT
);
  logic [NUM_SLOTS-1:0] w_r, w_g, w_b, w_opq;
  logic                 r_s1_vld, r_s1_shot;
  logic [2:0]           r_rgb;
  logic [NUM_SLOTS-1:0] r_hit;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    sprite_slot #(.SPR_W(SPR_W), .SPR_H(SPR_H), .CW(COORD_W)) u_slot (
      .i_clk        (CLK),
      .i_reset      (reset),
      .i_pix_en     (PIX_EN),
      .i_frame_start(FRAME_START),
      .i_x          (X_VGA),
      .i_y          (Y_VGA),
      .i_x_obj      (X_OBJETO[i*COORD_W +: COORD_W]),
      .i_y_obj      (Y_OBJETO[i*COORD_W +: COORD_W]),
      .i_alive      (ALIVE[i]),
      .i_mult       (MULTIPLICADOR),
      .i_bmp_r      (BITMAP_R),
      .i_bmp_g      (BITMAP_G),
      .i_bmp_b      (BITMAP_B),
      .o_r          (w_r[i]),
      .o_g          (w_g[i]),
      .o_b          (w_b[i]),
      .o_opaque     (w_opq[i])
    );
  end

  // Stage1 pixel-valid and shot delay, aligned with the slot index registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_shot <= 1'b0;
    end else begin
      r_s1_vld  <= PIX_EN;
      r_s1_shot <= PIX_EN & SHOT_PIXEL;
    end
  end

  // Stage2 colour: OR of all slots, held between pixels
  always_ff @(posedge CLK) begin
    if (reset)         r_rgb <= '0;
    else if (r_s1_vld) r_rgb <= {|w_r, |w_g, |w_b};
  end

  // Sticky hits; a new hit in the ack cycle wins
  always_ff @(posedge CLK) begin
    if (reset) r_hit <= '0;
    else       r_hit <= (r_hit & ~HIT_ACK) |
                        ({NUM_SLOTS{r_s1_vld & r_s1_shot}} & w_opq);
  end

  assign {R_VGA, G_VGA, B_VGA} = r_rgb;
  assign HIT = r_hit;
endmodule

// File: tb/tb_sprite_row_renderer.sv
// Bench for sprite_row_renderer: sparse-but-contiguous raster scans against a
// geometric reference (pixel lit iff inside scaled sprite box and bitmap set).
module tb_sprite_row_renderer;
  localparam int NS = 5, SW = 11, SH = 8, CW = 10, NP = SW * SH;

  logic CLK = 1'b0;
  logic reset, PIX_EN, FRAME_START, SHOT_PIXEL;
  logic [CW-1:0] X_VGA, Y_VGA;
  logic [NS*CW-1:0] X_OBJETO, Y_OBJETO;
  logic [NS-1:0] ALIVE, HIT_ACK, HIT;
  logic [3:0] MULTIPLICADOR;
  logic [NP-1:0] BITMAP_R, BITMAP_G, BITMAP_B;
  logic R_VGA, G_VGA, B_VGA;

  always #5 CLK = ~CLK;

  sprite_row_renderer #(.NUM_SLOTS(NS), .SPR_W(SW), .SPR_H(SH), .COORD_W(CW)) dut (
    .CLK(CLK), .reset(reset), .PIX_EN(PIX_EN), .FRAME_START(FRAME_START),
    .X_VGA(X_VGA), .Y_VGA(Y_VGA), .X_OBJETO(X_OBJETO), .Y_OBJETO(Y_OBJETO),
    .ALIVE(ALIVE), .MULTIPLICADOR(MULTIPLICADOR),
    .BITMAP_R(BITMAP_R), .BITMAP_G(BITMAP_G), .BITMAP_B(BITMAP_B),
    .SHOT_PIXEL(SHOT_PIXEL), .HIT_ACK(HIT_ACK),
    .R_VGA(R_VGA), .G_VGA(G_VGA), .B_VGA(B_VGA), .HIT(HIT)
  );

  // reference model state
  int sh_x[NS], sh_y[NS], sh_m;
  bit sh_alive[NS], sh_valid;
  logic [2:0] m_rgb, pend_rgb;
  logic [NS-1:0] m_hit, pend_hit;
  bit pend_pe;
  int n_tests, n_fail;

  function automatic logic [2:0] slot_px(int i, int x, int y);
    int row, col, b;
    if (!sh_valid || !sh_alive[i] || sh_x[i] >= 640 || sh_y[i] >= 480) return 3'b000;
    if (x < sh_x[i] || x >= sh_x[i] + SW * sh_m || y < sh_y[i] || y >= sh_y[i] + SH * sh_m)
      return 3'b000;
    row = (y - sh_y[i]) / sh_m;
    col = (x - sh_x[i]) / sh_m;
    b = NP - 1 - (row * SW + col);
    return {BITMAP_R[b], BITMAP_G[b], BITMAP_B[b]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance, update model, compare (output shows the pixel
  // driven two cycles earlier, i.e. the previous step).
  task automatic step(input bit pe, input int x, input int y, input bit shot,
                      input bit fs, input bit rst, input logic [NS-1:0] ack);
    logic [2:0] c_rgb;
    logic [NS-1:0] c_hit;
    c_rgb = '0;
    c_hit = '0;
    for (int i = 0; i < NS; i++) begin
      logic [2:0] p;
      p = slot_px(i, x, y);
      c_rgb = c_rgb | p;
      c_hit[i] = pe && shot && (p != 3'b000);
    end
    reset = rst; PIX_EN = pe; X_VGA = CW'(x); Y_VGA = CW'(y);
    SHOT_PIXEL = shot; FRAME_START = fs; HIT_ACK = ack;
    @(posedge CLK); #1;
    if (rst) begin
      m_rgb = '0; m_hit = '0; pend_pe = 1'b0; sh_valid = 1'b0;
    end else begin
      m_hit = m_hit & ~ack;
      if (pend_pe) begin
        m_rgb = pend_rgb;
        m_hit = m_hit | pend_hit;
      end
      pend_pe = pe; pend_rgb = c_rgb; pend_hit = c_hit;
      if (fs) begin
        for (int i = 0; i < NS; i++) begin
          sh_x[i] = int'(X_OBJETO[i*CW +: CW]);
          sh_y[i] = int'(Y_OBJETO[i*CW +: CW]);
          sh_alive[i] = ALIVE[i];
        end
        sh_m = (MULTIPLICADOR == 4'd0) ? 1 : int'(MULTIPLICADOR);
        sh_valid = 1'b1;
      end
    end
    chk("rgb", 32'({R_VGA, G_VGA, B_VGA}), 32'(m_rgb));
    chk("hit", 32'(HIT), 32'(m_hit));
  endtask

  task automatic fstart();
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  // Lines y0..y1: x=0, contiguous window lo..hi (random idle gaps), x=639
  task automatic render(input int y0, input int y1, input int lo, input int hi,
                        input bit shots, input bit scramble);
    for (int y = y0; y <= y1; y++) begin
      if (scramble && y == (y0 + y1) / 2) begin
        X_OBJETO = (NS*CW)'({$urandom, $urandom});
        Y_OBJETO = (NS*CW)'({$urandom, $urandom});
        ALIVE = NS'($urandom);
        MULTIPLICADOR = 4'($urandom);
      end
      step(1'b1, 0, y, 1'b0, 1'b0, 1'b0, '0);
      for (int x = lo; x <= hi; x++) begin
        if ($urandom_range(0, 7) == 0) step(1'b0, x, y, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, x, y, shots && ($urandom_range(0, 3) == 0), 1'b0, 1'b0, '0);
      end
      step(1'b1, 639, y, 1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y);
    X_OBJETO[i*CW +: CW] = CW'(x);
    Y_OBJETO[i*CW +: CW] = CW'(y);
  endtask

  task automatic rand_bitmap();
    BITMAP_R = NP'({$urandom, $urandom, $urandom});
    BITMAP_G = NP'({$urandom, $urandom, $urandom});
    BITMAP_B = NP'({$urandom, $urandom, $urandom});
  endtask

  initial begin
    int m, bx, by;
    logic [NP-1:0] bm;
    n_tests = 0; n_fail = 0;
    sh_valid = 1'b0; sh_m = 1; pend_pe = 1'b0; m_rgb = '0; m_hit = '0;
    for (int i = 0; i < NS; i++) begin sh_x[i] = 0; sh_y[i] = 0; sh_alive[i] = 1'b0; end
    reset = 1'b1; PIX_EN = 1'b0; FRAME_START = 1'b0; SHOT_PIXEL = 1'b0; HIT_ACK = '0;
    X_VGA = '0; Y_VGA = '0; X_OBJETO = '0; Y_OBJETO = '0; ALIVE = '0; MULTIPLICADOR = '0;
    BITMAP_R = '0; BITMAP_G = '0; BITMAP_B = '0;

    // reset, then nothing drawn until a FRAME_START
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, '0);
    BITMAP_R = '1; BITMAP_G = '1; BITMAP_B = '1;
    for (int i = 0; i < NS; i++) set_slot(i, 300 + 20 * i, 200);
    set_slot(0, 100, 50); ALIVE = 5'b00001; MULTIPLICADOR = 4'd2;
    render(48, 52, 95, 130, 1'b0, 1'b0);

    // all-ones at (100,50) x2, reset mid-frame, then a clean frame
    fstart(); render(48, 58, 95, 130, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 131, 58, 1'b0, 1'b0, 1'b1, '0);
    render(59, 67, 95, 130, 1'b0, 1'b0);
    fstart(); render(48, 67, 95, 130, 1'b0, 1'b0);
    chk("rgb_after_sprite", 32'({R_VGA, G_VGA, B_VGA}), 32'd0);

    // checker bitmap, MULT 0 and 1 render identically
    for (int b = 0; b < NP; b++) bm[b] = 1'(((NP - 1 - b) / SW + (NP - 1 - b) % SW) % 2);
    BITMAP_R = bm; BITMAP_G = ~bm; BITMAP_B = '0;
    bx = $urandom_range(2, 500); by = $urandom_range(1, 400);
    set_slot(0, bx, by); ALIVE = 5'b00001;
    for (int k = 0; k < 2; k++) begin
      MULTIPLICADOR = 4'(k);
      fstart(); render(by - 1, by + SH + 1, bx - 1, bx + SW + 2, 1'b0, 1'b0);
    end

    // spaced row, alive 10101, mid-frame input scramble, next frame changes
    rand_bitmap();
    m = $urandom_range(1, 2);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NS; i++) set_slot(i, 20 + 40 * i, 30);
      ALIVE = (k == 2) ? 5'b01110 : 5'b10101;
      MULTIPLICADOR = 4'(m);
      fstart(); render(29, 30 + SH * m + 1, 15, 180 + SW * m + 2, 1'b0, k == 0);
    end

    // right-edge clipping at x=635
    rand_bitmap(); BITMAP_R = '1;
    set_slot(0, 635, 10); ALIVE = 5'b00001; MULTIPLICADOR = 4'd1;
    fstart(); render(9, 19, 600, 638, 1'b0, 1'b0);

    // FRAME_START mid-frame restarts the slots
    rand_bitmap();
    for (int i = 0; i < NS; i++) set_slot(i, 20 + 40 * i, 30);
    ALIVE = 5'b11111; MULTIPLICADOR = 4'd1;
    fstart(); render(29, 34, 15, 200, 1'b0, 1'b0);
    fstart(); render(29, 40, 15, 200, 1'b0, 1'b0);

    // random shots over all slots, then acknowledge everything
    rand_bitmap();
    for (int i = 0; i < NS; i++) set_slot(i, 20 + 40 * i, 60);
    fstart(); render(59, 69, 15, 200, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, '1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, '0);

    // directed hits on slot 3: set wins over ack, transparent pixel never hits
    bm = '1; bm[NP - 1 - 7] = 1'b0;
    BITMAP_R = bm; BITMAP_G = bm; BITMAP_B = bm;
    set_slot(3, 200, 100); ALIVE = 5'b01000;
    fstart();
    step(1'b1, 0, 100, 1'b0, 1'b0, 1'b0, '0);
    for (int x = 199; x <= 204; x++) step(1'b1, x, 100, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 205, 100, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 206, 100, 1'b0, 1'b0, 1'b0, 5'b01000);
    chk("hit_set_wins", 32'(HIT), 32'(5'b01000));
    step(1'b1, 207, 100, 1'b1, 1'b0, 1'b0, 5'b01000);
    chk("hit_ack_clear", 32'(HIT), 32'd0);
    step(1'b1, 208, 100, 1'b0, 1'b0, 1'b0, '0);
    chk("hit_transparent", 32'(HIT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
